// File: rtl/bg_theme_pkg.sv
// rtl/bg_theme_pkg.sv - shared types, theme table and channel step helpers for the theme controller
package bg_theme_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    rgb332_t    bg;
    rgb332_t    border;
    logic [5:0] width;
  } theme_t;

  typedef enum logic {
    IDLE,
    FADE
  } fsm_t;

  localparam logic [7:0] FLASH_COLOR_DEFAULT = 8'hFC;

  localparam theme_t THEME_TABLE [4] = '{
    {8'h1F, 8'hE3, 6'd20},
    {8'h02, 8'h49, 6'd12},
    {8'h24, 8'h92, 6'd28},
    {8'hF4, 8'h6D, 6'd16}
  };

  // Move one unit toward the target; an equal channel stays put, so no wrap is possible.
  function automatic logic [2:0] step_toward3(input logic [2:0] c, input logic [2:0] t);
    if (c < t)      return c + 3'd1;
    else if (c > t) return c - 3'd1;
    else            return c;
  endfunction

  function automatic logic [1:0] step_toward2(input logic [1:0] c, input logic [1:0] t);
    if (c < t)      return c + 2'd1;
    else if (c > t) return c - 2'd1;
    else            return c;
  endfunction

endpackage

// File: rtl/rgb332_stepper.sv
// rtl/rgb332_stepper.sv - one fade step of an RGB332 colour toward its target
module rgb332_stepper
  import bg_theme_pkg::*;
(
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] next,
  output logic       equal
);

  rgb332_t c;
  rgb332_t t;
  rgb332_t n;

  assign c = cur;
  assign t = tgt;

  always_comb begin
    n   = c;
    n.r = step_toward3(c.r, t.r);
    n.g = step_toward3(c.g, t.g);
    n.b = step_toward2(c.b, t.b);
  end

  assign next  = n;
  assign equal = (cur == tgt);

endmodule

// File: rtl/bg_theme_controller.sv
// rtl/bg_theme_controller.sv - frame-synchronous background/border theme fader with border flash overlay
module bg_theme_controller
  import bg_theme_pkg::*;
#(
  parameter int         STEP_FRAMES  = 2,
  parameter int         BLINK_FRAMES = 8,
  parameter int         FLASH_BLINKS = 3,
  parameter logic [7:0] FLASH_COLOR  = FLASH_COLOR_DEFAULT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       theme_req,
  input  logic [1:0] theme_id,
  input  logic       flash_req,
  output logic       theme_ack,
  output logic       busy,
  output logic [7:0] bg_color,
  output logic [7:0] border_color,
  output logic [5:0] border_width
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] BLINK_LEN = 8'(BLINK_FRAMES);
  localparam logic [7:0] BLINKS    = 8'(FLASH_BLINKS);

  fsm_t       state;
  theme_t     sel;
  logic [7:0] tgt_bg, tgt_border;
  logic [5:0] tgt_width;
  logic [7:0] fade_bg, fade_border;
  logic [7:0] frame_cnt;
  logic       first_sof;

  logic       flash_active, flash_on;
  logic [7:0] blink_cnt, phase_cnt;

  logic [7:0] bg_step, bd_step;
  logic       bg_eq, bd_eq;

  logic [7:0] bg_n, bd_n, cnt_n;
  logic       fade_done;
  logic       f_active_n, f_on_n;
  logic [7:0] blink_n, phase_n;
  logic       overlay;

  assign sel      = THEME_TABLE[theme_id];
  assign bg_color = fade_bg;

  rgb332_stepper u_bg_step (
    .cur   (fade_bg),
    .tgt   (tgt_bg),
    .next  (bg_step),
    .equal (bg_eq)
  );

  rgb332_stepper u_border_step (
    .cur   (fade_border),
    .tgt   (tgt_border),
    .next  (bd_step),
    .equal (bd_eq)
  );

  always_comb begin
    bg_n      = fade_bg;
    bd_n      = fade_border;
    cnt_n     = frame_cnt;
    fade_done = 1'b0;
    if (state == FADE && startOfFrame) begin
      if (bg_eq && bd_eq) begin
        fade_done = 1'b1;
      end else if (frame_cnt == STEP_LAST) begin
        bg_n  = bg_step;
        bd_n  = bd_step;
        cnt_n = 8'd0;
      end else begin
        cnt_n = frame_cnt + 8'd1;
      end
    end
  end

  // phase_cnt==0 marks a freshly (re)loaded flash that has not reached its first SOF yet.
  always_comb begin
    f_active_n = flash_active;
    f_on_n     = flash_on;
    blink_n    = blink_cnt;
    phase_n    = phase_cnt;
    if (flash_req) begin
      f_active_n = 1'b1;
      f_on_n     = 1'b1;
      blink_n    = BLINKS;
      phase_n    = 8'd0;
    end else if (startOfFrame && flash_active) begin
      if (phase_cnt == 8'd0) begin
        phase_n = 8'd1;
      end else if (phase_cnt == BLINK_LEN) begin
        phase_n = 8'd1;
        if (flash_on) begin
          f_on_n  = 1'b0;
          blink_n = blink_cnt - 8'd1;
          if (blink_cnt == 8'd1) f_active_n = 1'b0;
        end else begin
          f_on_n = 1'b1;
        end
      end else begin
        phase_n = phase_cnt + 8'd1;
      end
    end
    overlay = flash_req ? (flash_active && flash_on && phase_cnt != 8'd0)
                        : (f_active_n && f_on_n && phase_n != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      tgt_bg       <= THEME_TABLE[0].bg;
      tgt_border   <= THEME_TABLE[0].border;
      tgt_width    <= THEME_TABLE[0].width;
      fade_bg      <= THEME_TABLE[0].bg;
      fade_border  <= THEME_TABLE[0].border;
      border_color <= THEME_TABLE[0].border;
      border_width <= THEME_TABLE[0].width;
      frame_cnt    <= 8'd0;
      first_sof    <= 1'b0;
      flash_active <= 1'b0;
      flash_on     <= 1'b0;
      blink_cnt    <= 8'd0;
      phase_cnt    <= 8'd0;
      theme_ack    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      theme_ack    <= 1'b0;
      flash_active <= f_active_n;
      flash_on     <= f_on_n;
      blink_cnt    <= blink_n;
      phase_cnt    <= phase_n;
      if (startOfFrame) border_color <= overlay ? FLASH_COLOR : bd_n;
      case (state)
        IDLE: begin
          if (theme_req) begin
            tgt_bg     <= sel.bg;
            tgt_border <= sel.border;
            tgt_width  <= sel.width;
            frame_cnt  <= 8'd0;
            first_sof  <= 1'b1;
            busy       <= 1'b1;
            state      <= FADE;
          end
        end
        FADE: begin
          if (startOfFrame) begin
            first_sof   <= 1'b0;
            if (first_sof) border_width <= tgt_width;
            fade_bg     <= bg_n;
            fade_border <= bd_n;
            frame_cnt   <= cnt_n;
            if (fade_done) begin
              theme_ack <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
